// File: rtl/usart_rx_deframer.sv
// UART receive deframer: oversampled 8E1 characters assembled into
// MSG_LENGTH-bit packets presented on a valid/ready handshake.
module usart_rx_deframer #(
  parameter int MSG_LENGTH   = 48,
  parameter int BAUD_DIV     = 434,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                  clk,
  input  logic                  rsnt,
  input  logic                  rx,
  output logic [MSG_LENGTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  parity_error,
  output logic                  frame_error,
  output logic                  overrun
);

  localparam int NCH  = MSG_LENGTH / 8;
  localparam int CW   = $clog2(BAUD_DIV);
  localparam int NW   = $clog2(NCH + 1);
  localparam int TLIM = TIMEOUT_BITS * BAUD_DIV;
  localparam int TW   = $clog2(TLIM + 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_IDLE
  } state_t;

  state_t                state_q, state_d;
  logic                  rx_m_q, rx_s_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [3:0]            bits_q, bits_d;
  logic [7:0]            chr_q, chr_d;
  logic [MSG_LENGTH-1:0] pkt_q, pkt_d;
  logic [NW-1:0]         nch_q, nch_d;
  logic                  acc_q, acc_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic [MSG_LENGTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  perr_q, perr_d;
  logic                  fe_q, fe_d;
  logic                  ovr_q, ovr_d;
  logic                  tick;
  logic                  done;

  always_ff @(posedge clk or negedge rsnt) begin
    if (!rsnt) begin
      rx_m_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bits_q  <= '0;
      chr_q   <= '0;
      pkt_q   <= '0;
      nch_q   <= '0;
      acc_q   <= 1'b0;
      tmr_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      rx_m_q  <= rx;
      rx_s_q  <= rx_m_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      chr_q   <= chr_d;
      pkt_q   <= pkt_d;
      nch_q   <= nch_d;
      acc_q   <= acc_d;
      tmr_q   <= tmr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    chr_d   = chr_q;
    pkt_d   = pkt_q;
    nch_d   = nch_q;
    acc_d   = acc_q;
    tmr_d   = tmr_q;
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    fe_d    = 1'b0;
    ovr_d   = 1'b0;
    done    = 1'b0;
    tick    = (cnt_q == '0);

    if (valid_q && ready) valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = CW'(BAUD_DIV / 2 - 1);
          tmr_d   = '0;
        end else if (nch_q != '0) begin
          // inter-character gap too long: silently drop partial packet
          if (tmr_q == TW'(TLIM - 1)) begin
            tmr_d = '0;
            nch_d = '0;
            acc_d = 1'b0;
          end else begin
            tmr_d = tmr_q + TW'(1);
          end
        end
      end
      START: begin
        if (!tick) begin
          cnt_d = cnt_q - CW'(1);
        end else if (rx_s_q) begin
          state_d = IDLE;
        end else begin
          state_d = DATA;
          cnt_d   = CW'(BAUD_DIV - 1);
          bits_d  = 4'd8;
        end
      end
      DATA: begin
        if (!tick) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          chr_d  = {rx_s_q, chr_q[7:1]};
          cnt_d  = CW'(BAUD_DIV - 1);
          bits_d = bits_q - 4'd1;
          if (bits_q == 4'd1) state_d = PARITY;
        end
      end
      PARITY: begin
        if (!tick) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          acc_d   = acc_q | (^chr_q ^ rx_s_q);
          cnt_d   = CW'(BAUD_DIV - 1);
          state_d = STOP;
        end
      end
      STOP: begin
        if (!tick) begin
          cnt_d = cnt_q - CW'(1);
        end else if (rx_s_q) begin
          pkt_d   = (pkt_q << 8) | MSG_LENGTH'(chr_q);
          nch_d   = nch_q + NW'(1);
          done    = (nch_q == NW'(NCH - 1));
          state_d = IDLE;
        end else begin
          fe_d    = 1'b1;
          nch_d   = '0;
          acc_d   = 1'b0;
          state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // a pending packet, even one being acked this cycle, forces a drop
    if (done) begin
      if (valid_q) begin
        ovr_d = 1'b1;
      end else begin
        data_d  = pkt_d;
        perr_d  = acc_d;
        valid_d = 1'b1;
      end
      nch_d = '0;
      acc_d = 1'b0;
    end
  end

  assign data         = data_q;
  assign valid        = valid_q;
  assign parity_error = perr_q;
  assign frame_error  = fe_q;
  assign overrun      = ovr_q;

endmodule
